// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC capture sequencer.
package adc_capture_pkg;
  localparam int MAX_LOG2 = 8;
  localparam int LEN_W    = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_TRIG,
    S_CAPTURE,
    S_DRAIN
  } state_e;

  function automatic logic [3:0] clamp_log2(input logic [3:0] v, input int max_v);
    return (int'(v) > max_v) ? 4'(max_v) : v;
  endfunction
endpackage

// File: rtl/adc_trig_detect.sv
// Rising level-crossing detector on the raw ADC stream.
module adc_trig_detect #(
  parameter int DATAWIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [DATAWIDTH-1:0] level,
  input  logic [DATAWIDTH-1:0] adcdata,
  output logic                 trig
);
  logic [DATAWIDTH-1:0] prev_q, prev_d;

  always_comb begin
    prev_d = (load || en) ? adcdata : prev_q;
    trig   = en && (prev_q < level) && (adcdata >= level);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= '0;
    else     prev_q <= prev_d;
  end
endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered, decimated, fixed-length ADC frame capture onto a valid/ready stream.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int DATAWIDTH = 14,
  parameter int MAX_LOG2  = adc_capture_pkg::MAX_LOG2,
  parameter int LEN_W     = adc_capture_pkg::LEN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 trig_mode,
  input  logic [DATAWIDTH-1:0] trig_level,
  input  logic [3:0]           ds_log2,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic [DATAWIDTH-1:0] adcdata,
  output logic [DATAWIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 cfg_err
);
  state_e               state_q, state_d;
  logic                 trig_mode_q, trig_mode_d;
  logic [DATAWIDTH-1:0] level_q, level_d;
  logic [3:0]           ds_q, ds_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [MAX_LOG2-1:0]  dcnt_q, dcnt_d, dmask;
  logic [DATAWIDTH-1:0] m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 overflow_q, overflow_d, cfg_err_q, cfg_err_d;
  logic                 trig, can_load;

  adc_trig_detect #(.DATAWIDTH(DATAWIDTH)) u_trig (
    .clk     (clk),
    .rst     (rst),
    .load    (state_q == S_ARM),
    .en      (state_q == S_WAIT_TRIG),
    .level   (level_q),
    .adcdata (adcdata),
    .trig    (trig)
  );

  always_comb begin
    state_d     = state_q;
    trig_mode_d = trig_mode_q;
    level_d     = level_q;
    ds_d        = ds_q;
    rem_d       = rem_q;
    dcnt_d      = dcnt_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    dmask       = ~({MAX_LOG2{1'b1}} << ds_q);
    // Single-entry output: a slot frees up in the same cycle the old word leaves.
    can_load    = !m_valid_q || m_ready;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: if (start) begin
        if (frame_len == '0) cfg_err_d = 1'b1;
        else begin
          state_d     = S_ARM;
          trig_mode_d = trig_mode;
          level_d     = trig_level;
          ds_d        = clamp_log2(ds_log2, MAX_LOG2);
          rem_d       = frame_len;
          overflow_d  = 1'b0;
        end
      end
      S_ARM: begin
        dcnt_d  = '0;
        state_d = trig_mode_q ? S_WAIT_TRIG : S_CAPTURE;
      end
      S_WAIT_TRIG: if (trig) state_d = S_CAPTURE;
      S_CAPTURE: begin
        dcnt_d = (dcnt_q + 1'b1) & dmask;
        if (dcnt_q == '0) begin
          // Dropped samples still consume count so frame timing is fixed.
          rem_d = rem_q - 1'b1;
          if (can_load) begin
            m_data_d  = adcdata;
            m_valid_d = 1'b1;
            m_last_d  = (rem_q == LEN_W'(1));
          end else begin
            overflow_d = 1'b1;
          end
          if (rem_q == LEN_W'(1)) begin
            if (can_load) state_d = S_DRAIN;
            else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_DRAIN: if (m_valid_q && m_ready && m_last_q) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      m_valid_d  = 1'b0;
      m_last_d   = 1'b0;
      done_d     = 1'b0;
      overflow_d = overflow_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      trig_mode_q <= 1'b0;
      level_q     <= '0;
      ds_q        <= '0;
      rem_q       <= '0;
      dcnt_q      <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_mode_q <= trig_mode_d;
      level_q     <= level_d;
      ds_q        <= ds_d;
      rem_q       <= rem_d;
      dcnt_q      <= dcnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: table of ready-sink captures plus corner sequences.
module tb_adc_capture_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0, abort = 1'b0, trig_mode = 1'b0, m_ready = 1'b1;
  logic [13:0] trig_level = '0;
  logic [3:0]  ds_log2 = '0;
  logic [9:0]  frame_len = '0;
  logic [13:0] adcdata, m_data;
  logic        m_valid, m_last, busy, done, overflow, cfg_err;

  int cyc = 0;
  bit wave = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  // Triangle: period 64, step 496; rising through 0x2000 between phase 16 and 17.
  function automatic logic [13:0] tri_f(input int c);
    int p;
    p = c % 64;
    return 14'((p < 32 ? p : 64 - p) * 496);
  endfunction

  assign adcdata = wave ? tri_f(cyc) : cyc[13:0];

  adc_capture_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .trig_mode(trig_mode),
    .trig_level(trig_level), .ds_log2(ds_log2), .frame_len(frame_len), .adcdata(adcdata),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy),
    .done(done), .overflow(overflow), .cfg_err(cfg_err)
  );

  int bdata[$], bcyc[$];
  bit blast[$];
  int done_n = 0, cfgerr_n = 0;
  always @(negedge clk) if (!rst) begin
    if (m_valid && m_ready) begin
      bdata.push_back(int'(m_data));
      bcyc.push_back(cyc);
      blast.push_back(m_last);
    end
    if (done) done_n <= done_n + 1;
    if (cfg_err) cfgerr_n <= cfgerr_n + 1;
  end

  int n_cmp = 0, n_bad = 0, base_b = 0, base_d = 0, base_c = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int tgt);
    while (cyc < tgt) step(1);
  endtask

  task automatic mark();
    base_b = bdata.size();
    base_d = done_n;
    base_c = cfgerr_n;
  endtask

  task automatic go(input bit tm, input int ds, input int len, output int t);
    trig_mode = tm; ds_log2 = 4'(ds); frame_len = 10'(len);
    start = 1'b1; t = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    k = 0;
    while (done_n == base_d && k < budget) begin step(1); k++; end
    step(2);
    chk({nm, "_done"}, done_n - base_d, 1);
  endtask

  // Regular beats: data = t+first+i*stp (ramp), seen one cycle after capture.
  task automatic chk_beats(input string nm, input int t, input int first, input int stp, input int n);
    chk({nm, "_nbeats"}, bdata.size() - base_b, n);
    for (int i = 0; i < n && base_b + i < bdata.size(); i++) begin
      chk({nm, "_data"}, bdata[base_b+i], (t + first + i*stp) & 16'h3fff);
      chk({nm, "_when"}, bcyc[base_b+i], t + first + 1 + i*stp);
      chk({nm, "_last"}, int'(blast[base_b+i]), int'(i == n-1));
    end
  endtask

  typedef struct { int ds; int len; int beats; int stp; } vec_t;
  vec_t tbl[5];

  initial begin
    int t, c;
    int ov_off[5];
    tbl[0] = '{2, 4, 4, 4};
    tbl[1] = '{0, 5, 5, 1};
    tbl[2] = '{15, 2, 2, 256};
    tbl[3] = '{3, 1, 1, 8};
    tbl[4] = '{1, 6, 6, 2};
    ov_off = '{2, 3, 7, 8, 9};

    step(2);
    chk("rst_valid", m_valid, 0); chk("rst_busy", busy, 0); chk("rst_data", m_data, 0);
    rst = 1'b0;
    step(2);
    chk("idle_busy", busy, 0); chk("idle_done", done, 0); chk("idle_ovf", overflow, 0);
    chk("idle_last", m_last, 0); chk("idle_cfgerr", cfg_err, 0);

    for (int v = 0; v < 5; v++) begin
      mark();
      go(1'b0, tbl[v].ds, tbl[v].len, t);
      wait_done($sformatf("vec%0d", v), tbl[v].len * tbl[v].stp + 20);
      chk_beats($sformatf("vec%0d", v), t, 2, tbl[v].stp, tbl[v].beats);
      chk($sformatf("vec%0d_ovf", v), overflow, 0);
      chk($sformatf("vec%0d_busy", v), busy, 0);
    end

    // Triggered capture, armed once on the rising side and once on the falling side.
    wave = 1'b1; trig_level = 14'h2000;
    for (int r = 0; r < 2; r++) begin
      wait_cyc(cyc + 1);
      while (cyc % 64 != (r == 0 ? 2 : 36)) step(1);
      mark();
      go(1'b1, 0, 2, t);
      c = t + 2;
      while (c % 64 != 17) c++;
      wait_done($sformatf("trig%0d", r), 200);
      chk($sformatf("trig%0d_n", r), bdata.size() - base_b, 2);
      if (bdata.size() - base_b == 2) begin
        chk($sformatf("trig%0d_d0", r), bdata[base_b], int'(tri_f(c + 1)));
        chk($sformatf("trig%0d_t0", r), bcyc[base_b], c + 2);
        chk($sformatf("trig%0d_ge", r), int'(bdata[base_b] >= 'h2000), 1);
        chk($sformatf("trig%0d_d1", r), bdata[base_b+1], int'(tri_f(c + 2)));
      end
    end
    wave = 1'b0;

    // Back-pressure mid-frame: three captures dropped, frame length still 8 captures.
    mark();
    go(1'b0, 0, 8, t);
    wait_cyc(t + 4); m_ready = 1'b0;
    wait_cyc(t + 7); m_ready = 1'b1;
    wait_done("ovf", 40);
    chk("ovf_n", bdata.size() - base_b, 5);
    for (int i = 0; i < 5 && base_b + i < bdata.size(); i++) begin
      chk("ovf_data", bdata[base_b+i], t + ov_off[i]);
      chk("ovf_last", int'(blast[base_b+i]), int'(i == 4));
    end
    chk("ovf_flag", overflow, 1);

    // Final sample dropped: straight to IDLE with done, no m_last.
    mark(); m_ready = 1'b0;
    go(1'b0, 0, 2, t);
    wait_cyc(t + 4);
    chk("dropfin_done", done, 1); chk("dropfin_busy", busy, 0);
    chk("dropfin_last", m_last, 0); chk("dropfin_data", m_data, t + 2);
    m_ready = 1'b1;
    step(2);
    chk("dropfin_n", bdata.size() - base_b, 1);
    chk("dropfin_dn", done_n - base_d, 1);

    // Abort with a word pending.
    mark();
    go(1'b0, 2, 8, t);
    wait_cyc(t + 8); m_ready = 1'b0;
    wait_cyc(t + 11);
    chk("abort_pre_valid", m_valid, 1);
    abort = 1'b1; step(1); abort = 1'b0;
    chk("abort_valid", m_valid, 0); chk("abort_busy", busy, 0); chk("abort_last", m_last, 0);
    m_ready = 1'b1;
    step(10);
    chk("abort_nodone", done_n - base_d, 0);
    chk("abort_n", bdata.size() - base_b, 2);
    mark();
    go(1'b0, 0, 3, t);
    wait_done("reabort", 30);
    chk_beats("reabort", t, 2, 1, 3);

    // Zero-length frame rejected.
    mark();
    go(1'b0, 0, 0, t);
    chk("cfg_err_pulse", cfg_err, 1); chk("cfg_busy", busy, 0);
    step(1);
    chk("cfg_err_clr", cfg_err, 0); chk("cfg_busy2", busy, 0);
    chk("cfg_err_n", cfgerr_n - base_c, 1);

    // start while busy is ignored.
    mark();
    go(1'b0, 1, 3, t);
    wait_cyc(t + 4);
    frame_len = 10'd7; ds_log2 = 4'd0; start = 1'b1; step(1); start = 1'b0;
    wait_done("busystart", 40);
    chk_beats("busystart", t, 2, 2, 3);

    // Reset while in DRAIN.
    mark(); m_ready = 1'b0;
    go(1'b0, 0, 1, t);
    wait_cyc(t + 5);
    chk("drain_busy", busy, 1); chk("drain_last", m_last, 1);
    rst = 1'b1; #1;
    chk("rstmid_data", m_data, 0); chk("rstmid_valid", m_valid, 0); chk("rstmid_last", m_last, 0);
    chk("rstmid_busy", busy, 0); chk("rstmid_done", done, 0); chk("rstmid_ovf", overflow, 0);
    chk("rstmid_cfg", cfg_err, 0);
    step(2); rst = 1'b0; m_ready = 1'b1;
    step(3);
    chk("post_busy", busy, 0); chk("post_valid", m_valid, 0);
    mark();
    go(1'b0, 0, 1, t);
    wait_done("post", 20);
    chk_beats("post", t, 2, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Sequencer for the ADC acquisition path. It arms on a start command, optionally waits for a level-crossing trigger on the raw ADC stream, then decimates by a runtime 2^n ratio and emits a fixed-length frame of samples on a valid/ready stream. It sits between the ADC input register and the frame buffer / DA playback logic, and replaces free-running decimation wherever a triggered, bounded capture is needed.

## Interface
- DATAWIDTH, 14, ADC sample width (offset-binary, unsigned)
- MAX_LOG2, 8, largest decimation exponent; decimation counter width
- LEN_W, 10, frame-length width
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches config and arms (ignored unless IDLE)
- abort  in  1  return to IDLE next cycle from any state
- trig_mode  in  1  0 = immediate, 1 = rising crossing of trig_level
- trig_level  in  DATAWIDTH  trigger threshold, latched at start
- ds_log2  in  4  decimation exponent, latched at start; values > MAX_LOG2 clamp to MAX_LOG2
- frame_len  in  LEN_W  samples per frame, latched at start; 0 is rejected
- adcdata  in  DATAWIDTH  ADC sample, valid every cycle
- m_data  out  DATAWIDTH  captured sample
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts when m_valid & m_ready
- m_last  out  1  qualifies final sample of frame
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame completion
- overflow  out  1  sticky: a sample was dropped; cleared by accepted start
- cfg_err  out  1  one-cycle pulse when start arrives with frame_len == 0

## Operation
- States: IDLE, ARM, WAIT_TRIG, CAPTURE, DRAIN.
- IDLE: start & frame_len != 0 -> ARM, latch config, clear overflow. start & frame_len == 0 -> pulse cfg_err, stay IDLE.
- ARM (exactly 1 cycle): loads prev_sample <= adcdata. trig_mode 0 -> CAPTURE; 1 -> WAIT_TRIG.
- WAIT_TRIG: trigger when prev_sample < trig_level and adcdata >= trig_level (unsigned); prev_sample updates every cycle. Trigger -> CAPTURE next cycle.
- CAPTURE: decimation counter dcnt starts at 0 on entry and increments mod 2^ds_log2 each cycle. Capture cycle when dcnt == 0: adcdata loads the output register, remaining count decrements. ds_log2 = 0 captures every cycle.
- Output register is single-entry. A capture while m_valid & !m_ready drops the new sample, sets overflow, and still decrements the count, so frame timing stays fixed.
- The final capture sets m_last with its data, then -> DRAIN. If the final sample is dropped, go straight to IDLE and pulse done on that cycle; no m_last is emitted for that frame.
- DRAIN: wait for m_valid & m_ready & m_last, pulse done in that cycle, -> IDLE.
- abort: -> IDLE next cycle; m_valid and m_last clear; done does not pulse; overflow holds.
- start while busy: ignored, no effect.

## Timing
- Reset: state IDLE; m_data 0, m_valid 0, m_last 0, busy 0, done 0, overflow 0, cfg_err 0; counters 0.
- start in cycle t -> busy at t+1 (ARM).
- Immediate mode: first CAPTURE cycle t+2, m_valid t+3.
- Trigger: detect in cycle t -> first capture t+1 -> m_valid t+2.
- With a ready sink, successive m_valid beats are spaced 2^ds_log2 cycles apart.
- m_valid stays high until accepted; m_data is stable while m_valid & !m_ready.
- The output register accepts a new capture in the same cycle the old word is accepted.
- done is registered (cycle after the qualifying handshake or drop).
- busy falls in the same cycle done is high.

## Structure
- Package adc_capture_pkg: state enum, MAX_LOG2, LEN_W default, clamp helper function for ds_log2.
- Sub-module adc_trig_detect: prev_sample register plus comparator; inputs load/enable; output trig pulse.
- Everything else stays in the top-level FSM.

## Test plan
- Immediate, ds_log2=2, frame_len=4, ramp adcdata=cycle index, m_ready=1 -> 4 beats spaced 4 cycles, data step 4, m_last on beat 4, done once.
- Trigger level 0x2000, sine crossing upward -> first m_data is the sample at the detect cycle + 1, and >= 0x2000. A downward crossing must not trigger.
- ds_log2=0, frame_len=8, m_ready low for 3 cycles mid-frame -> overflow=1, 8 counted captures, fewer beats delivered, done still pulses.
- abort during CAPTURE after 2 beats -> IDLE next cycle, m_valid=0, no done. A new start with frame_len=3 yields exactly 3 beats.
- start with frame_len=0 -> cfg_err pulse, busy stays 0. ds_log2=15 -> spacing 256 cycles. start while busy -> no effect.
- rst asserted mid-DRAIN -> all outputs 0 immediately; after release the block is IDLE.
